// File: rtl/input_pingpong_memory.sv
// Double-buffered input frame memory. The write stream fills one bank
// sequentially while the compute side randomly reads the other, completed bank.
// Read data returns with a fixed two-cycle latency into a small output FIFO.
// Requests are admitted only while the FIFO holds a free slot for every
// outstanding request, so downstream backpressure never drops a response.
module input_pingpong_memory #(
  parameter int ADD_SIZE   = 12,
  parameter int DATA_SIZE  = 108,
  parameter int FRAME_LEN  = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] dataIn,
  input  logic                 read_en,
  output logic                 read_ready,
  input  logic [ADD_SIZE-1:0]  read_address,
  output logic [DATA_SIZE-1:0] dataOut,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 read_release,
  output logic                 wr_bank,
  output logic                 rd_bank,
  output logic [1:0]           bank_full
);

  localparam int MEM_WORDS = 2 * (2 ** ADD_SIZE);
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADD_SIZE-1:0] LAST_ADDR = ADD_SIZE'(FRAME_LEN - 1);
  localparam logic [ADD_SIZE:0]   FRAME_END = (ADD_SIZE + 1)'(FRAME_LEN);
  localparam logic [CNT_W:0]      DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]    LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  // Both banks live in one array; the bank select is the top address bit.
  logic [DATA_SIZE-1:0] mem [MEM_WORDS];

  logic [ADD_SIZE-1:0]  wr_addr;
  logic [1:0]           bank_full_nxt;

  logic                 wr_fire;
  logic                 wr_last;
  logic                 rd_fire;
  logic                 release_take;
  logic [1:0]           inflight;
  logic [CNT_W:0]       occupancy;
  logic                 credit_ok;

  // Read pipeline registers
  logic                 vld_p0;
  logic [ADD_SIZE-1:0]  addr_p0;
  logic                 oob_p0;
  logic                 vld_p1;
  logic [DATA_SIZE-1:0] rdata_p1;

  // Output FIFO
  logic [DATA_SIZE-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     fifo_wr_ptr;
  logic [PTR_W-1:0]     fifo_rd_ptr;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_push;
  logic                 fifo_pop;

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshakes, credit accounting and release qualification.
  always_comb begin
    in_ready     = !rst && !bank_full[wr_bank];
    wr_fire      = in_valid && in_ready;
    wr_last      = (wr_addr == LAST_ADDR);
    inflight     = {1'b0, vld_p0} + {1'b0, vld_p1};
    occupancy    = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
    credit_ok    = (occupancy < DEPTH_OCC);
    // A release may only retire the bank once no read of it is still in flight.
    release_take = read_release && bank_full[rd_bank] && (inflight == 2'd0);
    read_ready   = !rst && bank_full[rd_bank] && !release_take && credit_ok;
    rd_fire      = read_en && read_ready;
    fifo_push    = vld_p1;
    out_valid    = (fifo_count != '0);
    fifo_pop     = out_valid && out_ready;
    dataOut      = out_valid ? fifo_mem[fifo_rd_ptr] : '0;
  end

  // Next full flags: completion sets the write bank, release clears the read bank.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_fire && wr_last) begin
      bank_full_nxt[wr_bank] = 1'b1;
    end
    if (release_take) begin
      bank_full_nxt[rd_bank] = 1'b0;
    end
  end

  // Bank ownership and write address state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_addr   <= '0;
      bank_full <= 2'b00;
    end else begin
      bank_full <= bank_full_nxt;
      if (wr_fire) begin
        if (wr_last) begin
          wr_addr <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
      if (release_take) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  // Read pipeline valids; reset drops every outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      // p0: request accepted
      vld_p0 <= rd_fire;
      // p1: memory word captured
      vld_p1 <= vld_p0;
    end
  end

  // Frame memory write port and read datapath (no reset on data).
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank, wr_addr}] <= dataIn;
    end
    // p0: register the request address and its range check
    addr_p0 <= read_address;
    oob_p0  <= ({1'b0, read_address} >= FRAME_END);
    // p1: the read bank cannot change while a request is in flight
    rdata_p1 <= oob_p0 ? '0 : mem[{rd_bank, addr_p0}];
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_count  <= '0;
    end else begin
      if (fifo_push) begin
        fifo_wr_ptr <= ptr_inc(fifo_wr_ptr);
      end
      if (fifo_pop) begin
        fifo_rd_ptr <= ptr_inc(fifo_rd_ptr);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Output FIFO storage; p2: response written into the FIFO.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[fifo_wr_ptr] <= rdata_p1;
    end
  end

endmodule

// File: tb/tb_input_pingpong_memory.sv
// Self-checking bench for input_pingpong_memory: directed scenarios followed by
// a randomized phase, all compared every cycle against a queue-based model.
module tb_input_pingpong_memory;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int FL = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dataIn;
  logic          read_en;
  logic          read_ready;
  logic [AW-1:0] read_address;
  logic [DW-1:0] dataOut;
  logic          out_valid;
  logic          out_ready;
  logic          read_release;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    bank_full;

  input_pingpong_memory #(
    .ADD_SIZE(AW), .DATA_SIZE(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .dataIn(dataIn),
    .read_en(read_en), .read_ready(read_ready), .read_address(read_address),
    .dataOut(dataOut), .out_valid(out_valid), .out_ready(out_ready),
    .read_release(read_release),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame contents, bank flags, pending responses with due edge.
  logic [DW-1:0] m_mem [2][FL];
  logic          m_full [2];
  int            m_wb, m_rb, m_wa;
  int            edge_n;
  logic [DW-1:0] pend_d [$];
  int            pend_due [$];
  logic [DW-1:0] fq [$];
  bit            d_r_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    m_wb = 0;
    m_rb = 0;
    m_wa = 0;
    pend_d.delete();
    pend_due.delete();
    fq.delete();
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; dataIn = '0; read_en = 1'b0; read_address = '0;
    out_ready = 1'b0; read_release = 1'b0;
  endtask

  // One clock cycle: drive, check outputs against the model, step the model.
  task automatic cyc(input bit iv, input logic [DW-1:0] din, input bit re, input int ra,
                     input bit ordy, input bit rel);
    bit exp_ir, exp_rr, take, w_acc, r_acc;
    logic [DW-1:0] exp_do;
    in_valid = iv; dataIn = din; read_en = re; read_address = ra[AW-1:0];
    out_ready = ordy; read_release = rel;
    #1;
    exp_ir = !m_full[m_wb];
    take   = rel && m_full[m_rb] && (pend_d.size() == 0);
    exp_rr = m_full[m_rb] && !take && ((fq.size() + pend_d.size()) < FD);
    exp_do = (fq.size() != 0) ? fq[0] : '0;
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("read_ready", 32'(read_ready), 32'(exp_rr));
    chk("out_valid", 32'(out_valid), 32'(fq.size() != 0));
    chk("dataOut", 32'(dataOut), 32'(exp_do));
    chk("bank_full", 32'(bank_full), 32'({m_full[1], m_full[0]}));
    chk("wr_bank", 32'(wr_bank), 32'(m_wb));
    chk("rd_bank", 32'(rd_bank), 32'(m_rb));
    d_r_acc = re && read_ready;
    w_acc = iv && exp_ir;
    r_acc = re && exp_rr;
    @(posedge clk);
    if (fq.size() != 0 && ordy) void'(fq.pop_front());
    while (pend_due.size() != 0 && pend_due[0] == edge_n) begin
      fq.push_back(pend_d.pop_front());
      void'(pend_due.pop_front());
    end
    if (r_acc) begin
      pend_d.push_back((ra < FL) ? m_mem[m_rb][ra] : '0);
      pend_due.push_back(edge_n + 2);
    end
    if (w_acc) begin
      m_mem[m_wb][m_wa] = din;
      if (m_wa == FL - 1) begin
        m_full[m_wb] = 1'b1;
        m_wa = 0;
        m_wb ^= 1;
      end else begin
        m_wa++;
      end
    end
    if (take) begin
      m_full[m_rb] = 1'b0;
      m_rb ^= 1;
    end
    edge_n++;
    @(negedge clk);
  endtask

  // Asynchronous reset in the middle of the low clock phase.
  task automatic mid_reset();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dataOut", 32'(dataOut), 32'd0);
    chk("rst_bank_full", 32'(bank_full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_read_ready", 32'(read_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    idle_inputs();
    model_reset();
    edge_n = 0;
    #1;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_in_ready", 32'(in_ready), 32'd0);
    chk("init_dataOut", 32'(dataOut), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_bank_full", 32'(bank_full), 32'd0);

    // Basic fill of bank 0
    for (int i = 0; i < FL; i++) cyc(1'b1, DW'(16'h1000 + i), 1'b0, 0, 1'b1, 1'b0);
    chk("fill_bank_full", 32'(bank_full), 32'h1);
    chk("fill_wr_bank", 32'(wr_bank), 32'd1);
    chk("fill_rd_bank", 32'(rd_bank), 32'd0);
    chk("fill_in_ready", 32'(in_ready), 32'd1);

    // Read latency: address 3
    cyc(1'b0, '0, 1'b1, 3, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 0, 1'b1, 1'b0);
    chk("lat_k1_out_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, '0, 1'b0, 0, 1'b1, 1'b0);
    chk("lat_k2_out_valid", 32'(out_valid), 32'd1);
    chk("lat_k2_dataOut", 32'(dataOut), 32'h1003);
    // Back-to-back reads, out_ready high
    for (int i = 0; i < FL; i++) cyc(1'b0, '0, 1'b1, i, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 0, 1'b1, 1'b0);

    // Backpressure: six requests, out_ready low, then released
    n = 0;
    for (int c = 0; c < 12 && n < 6; c++) begin
      cyc(1'b0, '0, 1'b1, n, 1'b0, 1'b0);
      if (d_r_acc) n++;
    end
    chk("bp_accepted_stalled", 32'(n), 32'd4);
    for (int c = 0; c < 12 && n < 6; c++) begin
      cyc(1'b0, '0, 1'b1, n, 1'b1, 1'b0);
      if (d_r_acc) n++;
    end
    chk("bp_accepted_total", 32'(n), 32'd6);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0, 0, 1'b1, 1'b0);

    // Ping-pong stall: fill bank 1, 17th word blocks until release
    for (int i = 0; i < FL; i++) cyc(1'b1, DW'(16'h2000 + i), 1'b0, 0, 1'b1, 1'b0);
    chk("pp_bank_full", 32'(bank_full), 32'h3);
    cyc(1'b1, 16'h3000, 1'b0, 0, 1'b1, 1'b0);
    chk("pp_in_ready_stall", 32'(in_ready), 32'd0);
    cyc(1'b1, 16'h3000, 1'b0, 0, 1'b1, 1'b1);
    chk("pp_rel_bank_full", 32'(bank_full), 32'h2);
    chk("pp_rel_rd_bank", 32'(rd_bank), 32'd1);
    chk("pp_in_ready_resume", 32'(in_ready), 32'd1);
    cyc(1'b1, 16'h3000, 1'b0, 0, 1'b1, 1'b0);

    // Ignored release while a read is in flight, then re-issued
    cyc(1'b0, '0, 1'b1, 2, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 0, 1'b1, 1'b1);
    chk("ign_rd_bank", 32'(rd_bank), 32'd1);
    chk("ign_bank_full", 32'(bank_full), 32'h2);
    cyc(1'b0, '0, 1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 0, 1'b1, 1'b1);
    chk("retake_rd_bank", 32'(rd_bank), 32'd0);
    chk("retake_bank_full", 32'(bank_full), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < 6,
          int'($urandom_range(0, 15)), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    // Async reset with words in the FIFO and a half-filled bank
    mid_reset();
    for (int i = 0; i < FL; i++) cyc(1'b1, DW'(16'h4000 + i), 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(16'h4100 + i), 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, i + 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    mid_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 0, 1'b1, 1'b0);
    chk("no_stale_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < FL; i++) cyc(1'b1, DW'(16'h5000 + i), 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
    chk("post_rst_addr0", 32'(dataOut), 32'h5000);
    cyc(1'b0, '0, 1'b1, 12, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
